// File: rtl/div4bit_seq.sv
// div4bit_seq: sequential restoring divider for unsigned operands.
// One quotient bit per cycle, MSB first, with a busy/done handshake.
`default_nettype none

module div4bit_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;
    logic [N-1:0]  rem;
    logic [CW-1:0] cnt;
    logic          dz_int;

    logic [N:0]    rem_sh;
    logic [N-1:0]  rem_sub;
    logic          ge;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  dvd_next;

    // The restored remainder is always below the divisor, so N bits hold it;
    // only the shifted value needs the extra top bit for the compare.
    always_comb begin
        rem_sh   = {rem, dvd[N-1]};
        ge       = (rem_sh >= {1'b0, dvs});
        rem_sub  = rem_sh[N-1:0] - dvs;
        rem_next = ge ? rem_sub : rem_sh[N-1:0];
        dvd_next = {dvd[N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            dz_int <= 1'b0;
            q      <= '0;
            r      <= '0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd    <= a;
                        dvs    <= b;
                        rem    <= '0;
                        cnt    <= CW'(N - 1);
                        dz_int <= (b == '0);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    dvd <= dvd_next;
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    // Results are published straight from the final iteration.
                    if (cnt == '0) begin
                        q     <= dvd_next;
                        r     <= rem_next;
                        dz    <= dz_int;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_div4bit_seq.sv
// tb_div4bit_seq: scoreboard bench for div4bit_seq (N=4).
`default_nettype none

module tb_div4bit_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           done_at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_run = 0;

    logic [N-1:0] ha [14] = '{4'd14, 4'd3, 4'd7, 4'd1, 4'd15, 4'd2, 4'd11,
                              4'd4, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd12};
    logic [N-1:0] hb [14] = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd2,
                              4'd7, 4'd1, 4'd3, 4'd6, 4'd2, 4'd9, 4'd1};

    div4bit_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [N-1:0] ea, input logic [N-1:0] eb,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
        exp_t e;
        e.a = ea; e.b = eb; e.q = eq; e.r = er; e.dz = edz;
        e.done_at = cyc + N;
        sb.push_back(e);
    endtask

    // Issue one division from IDLE and return at the edge after DONE.
    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1;
        push(ia, ib, eq, er, edz);
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib;
        repeat (N + 1) @(posedge clk);
    endtask

    // Monitor: compares each done pulse against the oldest expectation.
    initial begin
        exp_t e;
        int   qi, ri, bi, ai;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                check("busy_during_done", busy, 0);
                check("busy_len", busy_run, N);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 required no pending result (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("q", q, e.q);
                    check("r", r, e.r);
                    check("dz", dz, e.dz);
                    check("latency", cyc, e.done_at);
                    if (e.b != 0) begin
                        qi = q; ri = r; bi = e.b; ai = e.a;
                        check("q_times_b_plus_r", qi * bi + ri, ai);
                        check("r_lt_b", ri < bi, 1);
                    end
                end
            end
            busy_run = busy ? busy_run + 1 : 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;

        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        issue(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        issue(4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
        issue(4'd0, 4'd5, 4'd0, 4'd0, 1'b0);

        // start held high, operands changing every cycle: accepts at 0, 6, 12.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            a = ha[k]; b = hb[k]; start = 1'b1;
            @(posedge clk);
            #1;
            if (k == 0)  push(4'd14, 4'd5, 4'd2, 4'd4, 1'b0);
            if (k == 6)  push(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);
            if (k == 12) push(4'd9, 4'd9, 4'd1, 4'd0, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(posedge clk);

        issue(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);

        // Reset sampled at edge 2 of a 14/4 division aborts it.
        @(negedge clk);
        a = 4'd14; b = 4'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        issue(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                if (bi == 0)
                    issue(N'(ai), 4'd0, 4'd15, N'(ai), 1'b1);
                else
                    issue(N'(ai), N'(bi), N'(ai / bi), N'(ai % bi), 1'b0);
            end
        end

        repeat (N + 2) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
